fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage directly downstream of the branch unit's `PCsrc` decision. It owns the program counter and drives the instruction-memory address. It applies taken-branch and jump redirects and registers the fetched instruction into the IF/ID pipeline register. It also inserts bubbles on redirects, holds on hazard stalls and traps misaligned targets.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PCsrc`  in  1  redirect request from branch unit (taken branch, jal, jalr).
- `target`  in  32  redirect destination, valid when `PCsrc`=1.
- `stall`  in  1  hazard unit holds PC and IF/ID.
- `imem_addr`  out  32  instruction-memory address (= current PC).
- `imem_rdata`  in  32  instruction word, combinational from `imem_addr` in the same cycle.
- `if_id_pc`  out  32  PC of the instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_nop`  out  1  1 = IF/ID holds a bubble; feeds the downstream `nop` inputs.
- `fetch_fault`  out  1  sticky misaligned-target trap.
- `redirect_count`  out  32  number of accepted redirects.

## Operation
- States:
  - BOOT: one cycle after reset.
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- BOOT:
  - PC holds `RESET_PC` and IF/ID holds a bubble.
  - Next state is always RUN; `PCsrc` and `stall` are ignored.
- RUN, priority redirect > stall > advance:
  - Redirect (`PCsrc`=1, `target[1:0]`=0): PC <= `target`; IF/ID <= bubble (`if_id_instr`=`NOP_INSTR`, `if_id_nop`=1, `if_id_pc`=0); `redirect_count` += 1. Applies even while `stall`=1, because the flush overrides the stall.
  - Redirect with `target[1:0]`!=0: PC unchanged; IF/ID <= bubble; `fetch_fault` <= 1; state <= FAULT; `redirect_count` not incremented.
  - Stall (`stall`=1, `PCsrc`=0): PC, IF/ID and counter all hold.
  - Advance: PC <= PC+4 (mod 2^32); `if_id_instr` <= `imem_rdata`; `if_id_pc` <= PC; `if_id_nop` <= 0.
- FAULT:
  - PC and `redirect_count` hold.
  - IF/ID is forced to a bubble every cycle.
  - All inputs except `reset` are ignored.
- `imem_addr` = PC at all times.
- Arithmetic:
  - PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no fault.
  - `redirect_count` wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values:
  - PC = `RESET_PC`; `imem_addr` = `RESET_PC`.
  - `if_id_pc` = 0, `if_id_instr` = `NOP_INSTR`, `if_id_nop` = 1.
  - `fetch_fault` = 0, `redirect_count` = 0, state = BOOT.
- Reset during any state, including FAULT, takes effect at the next rising edge and overrides all other inputs.
- Fetch latency: the instruction at PC appears on `if_id_instr` one cycle after PC is presented.
- Redirect latency:
  - `PCsrc` is sampled at edge N; `imem_addr` = `target` after edge N.
  - IF/ID is a bubble during cycle N+1, and the target instruction is in IF/ID after edge N+1.
  - The redirect penalty is exactly one bubble per accepted redirect.
- Back-to-back redirects on consecutive edges: each is applied and counted, and IF/ID remains a bubble throughout.
- When `stall` deasserts, advance resumes on the same edge with no extra bubble.
- Requirement on the branch unit: `PCsrc` and `target` must be stable across the sampling edge; the `PCsrc` negedge clear is outside this block.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` value.
  - `RESET_PC` default.
  - The fetch state enum (BOOT, RUN, FAULT).
  - Opcode constants for branch (7'h63), jal (7'h6F) and jalr (7'h67), already used by the branch unit.
- One natural sub-module, `if_id_reg`: a 32+32+1-bit pipeline register with hold (`stall`) and flush (bubble-load) controls; `fetch_stage` instantiates it.

## Test plan
- Reset then free-run, `imem_rdata`=PC-derived pattern: cycle after reset shows a bubble, then `if_id_pc` = 0, 4, 8… with matching instructions; `fetch_fault`=0.
- `PCsrc`=1, `target`=32'h100 at PC=32'h20: next `imem_addr`=32'h100; one bubble; then `if_id_pc`=32'h100; `redirect_count`=1.
- `stall`=1 for 3 cycles at PC=32'h40, then a redirect to 32'h80 with `stall` still 1: PC and IF/ID hold 3 cycles, then PC=32'h80 and a bubble is inserted.
- Redirect to 32'h102: `fetch_fault`=1 next cycle, PC unchanged, IF/ID bubbles; later redirects are ignored; `reset` restores PC=`RESET_PC` and clears the fault.
- Redirects on 4 consecutive edges to 32'h10, 32'h20, 32'h30, 32'h40: `redirect_count`=4, 4 bubbles, then 32'h40 is fetched.
- `RESET_PC`=32'hFFFF_FFF8, free-run: PC wraps to 32'h0 after 32'hFFFF_FFFC with no fault; `redirect_count` preset near 32'hFFFF_FFFF wraps to 0 on a redirect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline: bubble encoding, reset vector,
// fetch-stage state encoding and the control-flow opcodes the branch unit decodes.
package riscv_pkg;

    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Instruction addresses must be word aligned; only the two low bits matter.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 32-bit PC, 32-bit instruction and a bubble flag.
// Flush (bubble load) wins over stall (hold), which wins over a normal load.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_instr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        nop
);

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            pc    <= 32'h0000_0000;
            instr <= NOP_INSTR;
            nop   <= 1'b1;
        end else if (!stall) begin
            pc    <= next_pc;
            instr <= next_instr;
            nop   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, applies branch-unit redirects, inserts one
// bubble per redirect, honours hazard stalls and traps misaligned targets.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR   = RV_NOP_INSTR,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCsrc,
    input  logic [31:0] target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_nop,
    output logic        fetch_fault,
    output logic [31:0] redirect_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  count;
    logic         fault;
    logic         flush;

    // Outside RUN the register is always bubbled; inside RUN a redirect
    // flushes even when stall is high, because the flush overrides the hold.
    assign flush = (state != RUN) || PCsrc;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .stall      (stall),
        .next_pc    (pc),
        .next_instr (imem_rdata),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .nop        (if_id_nop)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            fault <= 1'b0;
            count <= COUNT_RESET;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (PCsrc) begin
                        if (is_aligned(target[1:0])) begin
                            pc    <= target;
                            count <= count + 32'd1;
                        end else begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end
                    end else if (!stall) begin
                        pc <= pc + 32'd4;
                    end
                end
                FAULT: state <= FAULT;
                default: state <= BOOT;
            endcase
        end
    end

    assign imem_addr      = pc;
    assign fetch_fault    = fault;
    assign redirect_count = count;

endmodule
